// File: rtl/pgm_ddram_arbiter.sv
// -----------------------------------------------------------------------------
// pgm_ddram_arbiter
//
// Shares the single DDRAM Avalon master of the PGM core between three
// requesters: the HPS ROM-download writer, the 68k program-ROM fetch and the
// graphics/sprite fetch. Byte addresses from each requester are turned into
// 64-bit DDRAM word addresses inside the core's DDR window. HPS downloads are
// paused through ioctl_wait while a download word is still waiting for DDRAM.
//
// Ports
//   clk_sys, reset_n        system clock, asynchronous active-low reset
//   dl_wr/dl_addr/dl_data   download strobe, byte address, 16-bit word
//   ioctl_wait              registered back-pressure to the HPS
//   cpu_req/cpu_addr        68k read strobe and byte address
//   cpu_data/cpu_ack        68k read word and its one-cycle valid
//   gfx_req/gfx_addr        graphics read strobe and byte address
//   gfx_data/gfx_ack        graphics read qword and its one-cycle valid
//   ddram_*                 Avalon master (single-beat bursts)
// -----------------------------------------------------------------------------
module pgm_ddram_arbiter #(
    parameter logic [28:0] DL_BASE = 29'h0600_0000,
    parameter logic [28:0] CPU_OFS = 29'h0000_0000,
    parameter logic [28:0] GFX_OFS = 29'h0010_0000
) (
    input  logic        clk_sys,
    input  logic        reset_n,

    input  logic        dl_wr,
    input  logic [26:0] dl_addr,
    input  logic [15:0] dl_data,
    output logic        ioctl_wait,

    input  logic        cpu_req,
    input  logic [23:0] cpu_addr,
    output logic [15:0] cpu_data,
    output logic        cpu_ack,

    input  logic        gfx_req,
    input  logic [25:0] gfx_addr,
    output logic [63:0] gfx_data,
    output logic        gfx_ack,

    input  logic        ddram_busy,
    output logic        ddram_rd,
    output logic        ddram_we,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic [3:0]  ddram_burstcnt,
    input  logic [63:0] ddram_dout,
    input  logic        ddram_dout_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t      state_reg;

    // Per-port pending requests. Only the address bits that matter are kept.
    logic        dl_pend_reg;
    logic [26:1] dl_addr_reg;
    logic [15:0] dl_data_reg;
    logic        cpu_pend_reg;
    logic [23:1] cpu_addr_reg;
    logic        gfx_pend_reg;
    logic [25:3] gfx_addr_reg;

    // Starvation guard: CPU grants issued while graphics was left waiting.
    logic [1:0]  streak_reg;

    // Which port owns the read in flight, and which 16-bit lane the CPU wants.
    logic        rd_gfx_reg;
    logic [1:0]  rd_lane_reg;

    // Low address bits that never reach DDRAM (word/qword alignment).
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{dl_addr[0], cpu_addr[0], gfx_addr[2:0]};

    assign ddram_burstcnt = 4'd1;

    // -------------------------------------------------------------------------
    // Completion events and port availability
    // -------------------------------------------------------------------------
    logic wr_accept;
    logic rd_return;
    logic dl_free;
    logic cpu_free;
    logic gfx_free;
    logic dl_take;
    logic cpu_take;
    logic gfx_take;

    // In WR the write command is always asserted, so !busy is the accept edge.
    assign wr_accept = (state_reg == ST_WR) && !ddram_busy;
    assign rd_return = (state_reg == ST_WAIT) && ddram_dout_ready;

    // A port is free when idle, or on the very edge that completes its
    // transaction; a strobe on that edge is therefore a fresh request.
    assign dl_free  = !dl_pend_reg  || wr_accept;
    assign cpu_free = !cpu_pend_reg || (rd_return && !rd_gfx_reg);
    assign gfx_free = !gfx_pend_reg || (rd_return &&  rd_gfx_reg);

    assign dl_take  = dl_wr   && dl_free;
    assign cpu_take = cpu_req && cpu_free;
    assign gfx_take = gfx_req && gfx_free;

    // -------------------------------------------------------------------------
    // Address translation and write data formatting
    // -------------------------------------------------------------------------
    logic [28:0] dl_word;
    logic [28:0] cpu_word;
    logic [28:0] gfx_word;
    logic [63:0] dl_rep;
    logic [7:0]  dl_be;
    logic [15:0] dout_lane [4];

    // 29-bit sums wrap silently at the top of the DDRAM space.
    assign dl_word  = DL_BASE + {5'd0, dl_addr_reg[26:3]};
    assign cpu_word = DL_BASE + CPU_OFS + {8'd0, cpu_addr_reg[23:3]};
    assign gfx_word = DL_BASE + GFX_OFS + {6'd0, gfx_addr_reg[25:3]};

    // Download word is replicated to all lanes; byte enables pick the lane.
    assign dl_be = 8'h03 << {dl_addr_reg[2:1], 1'b0};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign dl_rep[16*gi +: 16] = dl_data_reg;
            assign dout_lane[gi]       = ddram_dout[16*gi +: 16];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Arbitration (evaluated only in IDLE)
    // -------------------------------------------------------------------------
    logic gfx_starved;
    logic grant_dl;
    logic grant_cpu;
    logic grant_gfx;

    assign gfx_starved = gfx_pend_reg && (streak_reg == 2'd2);

    always_comb begin
        grant_dl  = 1'b0;
        grant_cpu = 1'b0;
        grant_gfx = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (dl_pend_reg) begin
                grant_dl = 1'b1;
            end else if (cpu_pend_reg && !gfx_starved) begin
                grant_cpu = 1'b1;
            end else if (gfx_pend_reg) begin
                grant_gfx = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending registers and download back-pressure
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_pend_reg  <= 1'b0;
            dl_addr_reg  <= '0;
            dl_data_reg  <= '0;
            cpu_pend_reg <= 1'b0;
            cpu_addr_reg <= '0;
            gfx_pend_reg <= 1'b0;
            gfx_addr_reg <= '0;
            ioctl_wait   <= 1'b0;
        end else begin
            if (dl_take) begin
                dl_pend_reg <= 1'b1;
                dl_addr_reg <= dl_addr[26:1];
                dl_data_reg <= dl_data;
                ioctl_wait  <= 1'b1;
            end else if (wr_accept) begin
                dl_pend_reg <= 1'b0;
                ioctl_wait  <= 1'b0;
            end

            if (cpu_take) begin
                cpu_pend_reg <= 1'b1;
                cpu_addr_reg <= cpu_addr[23:1];
            end else if (rd_return && !rd_gfx_reg) begin
                cpu_pend_reg <= 1'b0;
            end

            if (gfx_take) begin
                gfx_pend_reg <= 1'b1;
                gfx_addr_reg <= gfx_addr[25:3];
            end else if (rd_return && rd_gfx_reg) begin
                gfx_pend_reg <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer: one transaction in flight, all DDRAM outputs registered
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            ddram_rd    <= 1'b0;
            ddram_we    <= 1'b0;
            ddram_addr  <= '0;
            ddram_din   <= '0;
            ddram_be    <= '0;
            cpu_ack     <= 1'b0;
            gfx_ack     <= 1'b0;
            cpu_data    <= '0;
            gfx_data    <= '0;
            streak_reg  <= '0;
            rd_gfx_reg  <= 1'b0;
            rd_lane_reg <= '0;
        end else begin
            cpu_ack <= 1'b0;
            gfx_ack <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (grant_dl) begin
                        ddram_we   <= 1'b1;
                        ddram_addr <= dl_word;
                        ddram_din  <= dl_rep;
                        ddram_be   <= dl_be;
                        state_reg  <= ST_WR;
                    end else if (grant_cpu) begin
                        ddram_rd    <= 1'b1;
                        ddram_addr  <= cpu_word;
                        ddram_be    <= 8'hFF;
                        rd_gfx_reg  <= 1'b0;
                        rd_lane_reg <= cpu_addr_reg[2:1];
                        // Never passes 2: at 2 a waiting graphics port wins.
                        if (gfx_pend_reg) begin
                            streak_reg <= streak_reg + 2'd1;
                        end
                        state_reg <= ST_RD;
                    end else if (grant_gfx) begin
                        ddram_rd   <= 1'b1;
                        ddram_addr <= gfx_word;
                        ddram_be   <= 8'hFF;
                        rd_gfx_reg <= 1'b1;
                        streak_reg <= '0;
                        state_reg  <= ST_RD;
                    end
                end

                ST_WR: begin
                    if (!ddram_busy) begin
                        ddram_we  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                ST_RD: begin
                    if (!ddram_busy) begin
                        ddram_rd  <= 1'b0;
                        state_reg <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Read data seen in any other state is stray and dropped.
                    if (ddram_dout_ready) begin
                        if (rd_gfx_reg) begin
                            gfx_data <= ddram_dout;
                            gfx_ack  <= 1'b1;
                        end else begin
                            cpu_data <= dout_lane[rd_lane_reg];
                            cpu_ack  <= 1'b1;
                        end
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pgm_ddram_arbiter
//
// Drives the three requesters, models the DDRAM side (waitrequest, variable
// read latency, byte-enabled writes) and checks commands and acks against
// queues of expected results filled when the stimulus is applied.
// -----------------------------------------------------------------------------
module tb_pgm_ddram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        dl_wr;
    logic [26:0] dl_addr;
    logic [15:0] dl_data;
    logic        ioctl_wait;
    logic        cpu_req;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_ack;
    logic        gfx_req;
    logic [25:0] gfx_addr;
    logic [63:0] gfx_data;
    logic        gfx_ack;
    logic        ddram_busy;
    logic        ddram_rd;
    logic        ddram_we;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic [3:0]  ddram_burstcnt;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;

    always #10 clk_sys = ~clk_sys;

    pgm_ddram_arbiter dut (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .dl_wr            (dl_wr),
        .dl_addr          (dl_addr),
        .dl_data          (dl_data),
        .ioctl_wait       (ioctl_wait),
        .cpu_req          (cpu_req),
        .cpu_addr         (cpu_addr),
        .cpu_data         (cpu_data),
        .cpu_ack          (cpu_ack),
        .gfx_req          (gfx_req),
        .gfx_addr         (gfx_addr),
        .gfx_data         (gfx_data),
        .gfx_ack          (gfx_ack),
        .ddram_busy       (ddram_busy),
        .ddram_rd         (ddram_rd),
        .ddram_we         (ddram_we),
        .ddram_addr       (ddram_addr),
        .ddram_din        (ddram_din),
        .ddram_be         (ddram_be),
        .ddram_burstcnt   (ddram_burstcnt),
        .ddram_dout       (ddram_dout),
        .ddram_dout_ready (ddram_dout_ready)
    );

    typedef struct {
        logic        we;
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } cmd_t;

    cmd_t        exp_cmd_q [$];
    logic [15:0] exp_cpu_q [$];
    logic [63:0] exp_gfx_q [$];

    int tests_run    = 0;
    int tests_failed = 0;
    int rd_latency   = 1;
    int rsp_cnt      = 0;
    int cpu_ack_cnt  = 0;
    int gfx_ack_cnt  = 0;
    bit stray_req    = 1'b0;
    logic [63:0] rsp_data;

    logic [63:0] mem [logic [28:0]];

    function automatic logic [63:0] mem_rd(input logic [28:0] a);
        if (mem.exists(a)) return mem[a];
        return {3'b101, a, 3'b010, ~a};
    endfunction

    // DDRAM model and scoreboard, sampled mid-cycle.
    always @(negedge clk_sys) begin
        cmd_t        c;
        logic [15:0] e16;
        logic [63:0] e64;
        logic [63:0] w;
        if (!reset_n) begin
            rsp_cnt          = 0;
            ddram_dout_ready = 1'b0;
        end else begin
            if (cpu_ack) begin
                cpu_ack_cnt++;
                tests_run++;
                $display("[TB] cpu_ack data=%h", cpu_data);
                if (exp_cpu_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL cpu_ack_unexpected: got ack with data %h, required no ack", cpu_data);
                end else begin
                    e16 = exp_cpu_q.pop_front();
                    if (cpu_data !== e16) begin
                        tests_failed++;
                        $display("FAIL cpu_data: got %h, required %h", cpu_data, e16);
                    end
                end
            end
            if (gfx_ack) begin
                gfx_ack_cnt++;
                tests_run++;
                $display("[TB] gfx_ack data=%h", gfx_data);
                if (exp_gfx_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL gfx_ack_unexpected: got ack with data %h, required no ack", gfx_data);
                end else begin
                    e64 = exp_gfx_q.pop_front();
                    if (gfx_data !== e64) begin
                        tests_failed++;
                        $display("FAIL gfx_data: got %h, required %h", gfx_data, e64);
                    end
                end
            end

            // read response issued before this cycle's accept is examined
            ddram_dout_ready = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    ddram_dout_ready = 1'b1;
                    ddram_dout       = rsp_data;
                end
            end else if (stray_req) begin
                stray_req        = 1'b0;
                ddram_dout_ready = 1'b1;
                ddram_dout       = 64'hDEAD_BEEF_CAFE_F00D;
            end

            if ((ddram_rd || ddram_we) && !ddram_busy) begin
                tests_run++;
                $display("[TB] cmd %s addr=%h din=%h be=%h", ddram_we ? "WR" : "RD",
                         ddram_addr, ddram_din, ddram_be);
                if (exp_cmd_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL cmd_unexpected: got rd=%b we=%b addr=%h, required no command",
                             ddram_rd, ddram_we, ddram_addr);
                end else begin
                    c = exp_cmd_q.pop_front();
                    if (ddram_we !== c.we || ddram_rd !== !c.we || ddram_addr !== c.addr ||
                        (c.we && (ddram_din !== c.din || ddram_be !== c.be))) begin
                        tests_failed++;
                        $display("FAIL cmd: got we=%b rd=%b addr=%h din=%h be=%h, required we=%b addr=%h din=%h be=%h",
                                 ddram_we, ddram_rd, ddram_addr, ddram_din, ddram_be,
                                 c.we, c.addr, c.din, c.be);
                    end
                end
                if (ddram_we) begin
                    w = mem_rd(ddram_addr);
                    for (int b = 0; b < 8; b++)
                        if (ddram_be[b]) w[8*b +: 8] = ddram_din[8*b +: 8];
                    mem[ddram_addr] = w;
                end else begin
                    rsp_cnt  = rd_latency;
                    rsp_data = mem_rd(ddram_addr);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_cmd_q.size() != 0 || exp_cpu_q.size() != 0 || exp_gfx_q.size() != 0 ||
                rsp_cnt != 0 || ddram_rd || ddram_we) && n < 300) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (n >= 300) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: got %0d cmds %0d cpu %0d gfx outstanding, required 0",
                     name, exp_cmd_q.size(), exp_cpu_q.size(), exp_gfx_q.size());
            exp_cmd_q.delete();
            exp_cpu_q.delete();
            exp_gfx_q.delete();
        end
        @(posedge clk_sys); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; dl_wr = 0; dl_addr = '0; dl_data = '0;
        cpu_req = 0; cpu_addr = '0; gfx_req = 0; gfx_addr = '0;
        ddram_busy = 0; ddram_dout = '0; ddram_dout_ready = 0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        tests_run++;
        if ({ddram_rd, ddram_we, ddram_addr, ddram_din, ddram_be, ioctl_wait,
             cpu_ack, gfx_ack, cpu_data, gfx_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rd=%b we=%b addr=%h din=%h be=%h wait=%b ca=%b ga=%b cd=%h gd=%h, required all 0",
                     ddram_rd, ddram_we, ddram_addr, ddram_din, ddram_be, ioctl_wait,
                     cpu_ack, gfx_ack, cpu_data, gfx_data);
        end
        tests_run++;
        if (ddram_burstcnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL reset_burstcnt: got %h, required 1", ddram_burstcnt);
        end
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic test_download();
        exp_cmd_q.push_back('{we: 1'b1, addr: 29'h0600_0001, din: {4{16'hBEEF}}, be: 8'h0C});
        @(posedge clk_sys); #1;
        dl_wr = 1; dl_addr = 27'h000000A; dl_data = 16'hBEEF;
        @(negedge clk_sys);
        tests_run++;
        if (ioctl_wait !== 1'b0) begin
            tests_failed++;
            $display("FAIL ioctl_wait_T0: got %b, required 0", ioctl_wait);
        end
        @(posedge clk_sys); #1;
        dl_wr = 0;
        @(negedge clk_sys);
        tests_run++;
        if (ioctl_wait !== 1'b1 || ddram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL dl_T1: got wait=%b we=%b, required wait=1 we=0", ioctl_wait, ddram_we);
        end
        @(negedge clk_sys);
        tests_run++;
        if (ioctl_wait !== 1'b1 || ddram_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL dl_T2: got wait=%b we=%b, required wait=1 we=1", ioctl_wait, ddram_we);
        end
        @(negedge clk_sys);
        tests_run++;
        if (ioctl_wait !== 1'b0 || ddram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL dl_T3: got wait=%b we=%b, required wait=0 we=0", ioctl_wait, ddram_we);
        end
        wait_drain("download");
    endtask

    task automatic test_cpu_read();
        int n;
        mem[29'h0600_0000] = 64'h4444_3333_2222_1111;
        rd_latency = 5;
        exp_cmd_q.push_back('{we: 1'b0, addr: 29'h0600_0000, din: '0, be: '0});
        exp_cpu_q.push_back(16'h3333);
        @(posedge clk_sys); #1;
        cpu_req = 1; cpu_addr = 24'h000004;
        @(posedge clk_sys); #1;
        cpu_req = 0;
        wait_drain("cpu_read");

        // minimum strobe-to-ack with zero busy and one-cycle data
        rd_latency = 1;
        exp_cmd_q.push_back('{we: 1'b0, addr: 29'h0600_0000, din: '0, be: '0});
        exp_cpu_q.push_back(16'h2222);
        @(posedge clk_sys); #1;
        cpu_req = 1; cpu_addr = 24'h000002;
        @(posedge clk_sys); #1;
        cpu_req = 0;
        n = 1;
        while (!cpu_ack && n < 20) begin
            @(posedge clk_sys); #1;
            n++;
        end
        tests_run++;
        if (n != 4) begin
            tests_failed++;
            $display("FAIL cpu_latency: got %0d cycles, required 4", n);
        end
        wait_drain("cpu_latency");
    endtask

    task automatic test_simultaneous();
        int ca = cpu_ack_cnt;
        int ga = gfx_ack_cnt;
        logic [63:0] w;
        rd_latency = 2;
        exp_cmd_q.push_back('{we: 1'b1, addr: 29'h0600_0002, din: {4{16'h1234}}, be: 8'h03});
        exp_cmd_q.push_back('{we: 1'b0, addr: 29'h0600_0008, din: '0, be: '0});
        exp_cmd_q.push_back('{we: 1'b0, addr: 29'h0610_0020, din: '0, be: '0});
        w = mem_rd(29'h0600_0008);
        exp_cpu_q.push_back(w[63:48]);
        exp_gfx_q.push_back(mem_rd(29'h0610_0020));
        @(posedge clk_sys); #1;
        dl_wr = 1; dl_addr = 27'h0000010; dl_data = 16'h1234;
        cpu_req = 1; cpu_addr = 24'h000046;
        gfx_req = 1; gfx_addr = 26'h0000100;
        @(posedge clk_sys); #1;
        dl_wr = 0; cpu_req = 0; gfx_req = 0;
        wait_drain("simultaneous");
        tests_run++;
        if (cpu_ack_cnt - ca != 1 || gfx_ack_cnt - ga != 1) begin
            tests_failed++;
            $display("FAIL simul_ack_count: got cpu=%0d gfx=%0d, required 1 each",
                     cpu_ack_cnt - ca, gfx_ack_cnt - ga);
        end
    endtask

    task automatic test_starvation();
        int returns = 0;
        int n = 0;
        logic [63:0] w1, w2, w3, g;
        rd_latency = 2;
        w1 = mem_rd(29'h0600_0020);
        w2 = mem_rd(29'h0600_0041);
        w3 = mem_rd(29'h0600_0063);
        g  = mem_rd(29'h0610_0001);
        exp_cmd_q.push_back('{we: 1'b0, addr: 29'h0600_0020, din: '0, be: '0});
        exp_cmd_q.push_back('{we: 1'b0, addr: 29'h0600_0041, din: '0, be: '0});
        exp_cmd_q.push_back('{we: 1'b0, addr: 29'h0610_0001, din: '0, be: '0});
        exp_cmd_q.push_back('{we: 1'b0, addr: 29'h0600_0063, din: '0, be: '0});
        exp_cpu_q.push_back(w1[15:0]);
        exp_cpu_q.push_back(w2[15:0]);
        exp_cpu_q.push_back(w3[63:48]);
        exp_gfx_q.push_back(g);
        @(posedge clk_sys); #1;
        cpu_req = 1; cpu_addr = 24'h000100;
        gfx_req = 1; gfx_addr = 26'h0000008;
        @(posedge clk_sys); #1;
        cpu_req = 0; gfx_req = 0;
        // the CPU re-requests as each of its first two reads returns
        while (returns < 4 && n < 200) begin
            @(negedge clk_sys); #2;
            n++;
            if (ddram_dout_ready) begin
                returns++;
                if (returns <= 2) begin
                    cpu_req  = 1;
                    cpu_addr = (returns == 1) ? 24'h000208 : 24'h00031E;
                    @(posedge clk_sys); #1;
                    cpu_req = 0;
                end
            end
        end
        tests_run++;
        if (returns != 4) begin
            tests_failed++;
            $display("FAIL starve_returns: got %0d reads returned, required 4", returns);
        end
        wait_drain("starvation");
        tests_run++;
        if (gfx_data !== g) begin
            tests_failed++;
            $display("FAIL gfx_data_hold: got %h, required %h", gfx_data, g);
        end
    endtask

    task automatic test_busy_reset();
        int ca, ga;
        ddram_busy = 1;
        rd_latency = 20;
        exp_cmd_q.push_back('{we: 1'b0, addr: 29'h0600_0002, din: '0, be: '0});
        @(posedge clk_sys); #1;
        cpu_req = 1; cpu_addr = 24'h000010;
        @(posedge clk_sys); #1;
        cpu_req = 0;
        @(posedge clk_sys); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            tests_run++;
            if (ddram_rd !== 1'b1 || ddram_addr !== 29'h0600_0002) begin
                tests_failed++;
                $display("FAIL busy_hold[%0d]: got rd=%b addr=%h, required rd=1 addr=06000002",
                         i, ddram_rd, ddram_addr);
            end
        end
        @(posedge clk_sys); #1;
        ddram_busy = 0;
        repeat (4) @(posedge clk_sys);
        #1;
        reset_n = 0;
        repeat (2) @(posedge clk_sys);
        #1;
        exp_cmd_q.delete();
        exp_cpu_q.delete();
        exp_gfx_q.delete();
        reset_n = 1;
        ca = cpu_ack_cnt;
        ga = gfx_ack_cnt;
        stray_req = 1;
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        tests_run++;
        if (cpu_ack_cnt != ca || gfx_ack_cnt != ga) begin
            tests_failed++;
            $display("FAIL stray_ack: got %0d cpu %0d gfx acks, required 0",
                     cpu_ack_cnt - ca, gfx_ack_cnt - ga);
        end
        tests_run++;
        if ({ddram_rd, ddram_we, ddram_addr, ddram_din, ddram_be, ioctl_wait,
             cpu_ack, gfx_ack, cpu_data, gfx_data} !== '0 || ddram_burstcnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL post_reset_outputs: got rd=%b we=%b addr=%h din=%h be=%h wait=%b cd=%h gd=%h bc=%h, required reset values",
                     ddram_rd, ddram_we, ddram_addr, ddram_din, ddram_be, ioctl_wait,
                     cpu_data, gfx_data, ddram_burstcnt);
        end
    endtask

    initial begin
        test_reset();
        test_download();
        test_cpu_read();
        test_simultaneous();
        test_starvation();
        test_busy_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
